// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - opcodes, state encoding and datapath select encodings
package multicycle_ctrl_pkg;

  localparam logic [6:0] OP_RR     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

  localparam logic [1:0] WB_ALU   = 2'd0;
  localparam logic [1:0] WB_LOAD  = 2'd1;
  localparam logic [1:0] WB_LINK  = 2'd2;
  localparam logic [1:0] WB_IMM   = 2'd3;

  localparam logic ALU_A_RS1 = 1'b0;
  localparam logic ALU_A_PC  = 1'b1;
  localparam logic ALU_B_RS2 = 1'b0;
  localparam logic ALU_B_IMM = 1'b1;

  function automatic logic is_legal(input logic [6:0] op);
    return op inside {OP_RR, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
                      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
  endfunction

  function automatic logic uses_imm(input logic [6:0] op);
    return op inside {OP_IMM, OP_LOAD, OP_STORE, OP_JALR, OP_AUIPC};
  endfunction

endpackage

// File: rtl/multicycle_ctrl_wait_timer.sv
// rtl/multicycle_ctrl_wait_timer.sv - memory wait counter with clear, enable and expiry
module wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LAST = (TIMEOUT == 0) ? '0 : W'(TIMEOUT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  // Fires during the TIMEOUT-th consecutive idle cycle so that cycle decides the trap
  assign expired = (TIMEOUT != 0) && en && (count == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle instruction sequencer: fetch, decode, exec, mem, write-back
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] instr_opcode,
  input  logic       mem_ready,
  input  logic       branch_taken,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       ir_we,
  output logic       reg_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       alu_a_sel,
  output logic       alu_b_sel,
  output logic [1:0] wb_sel,
  output logic       retire,
  output logic       illegal,
  output logic       bus_err,
  output logic [2:0] state
);

  state_e     state_q, state_next;
  logic [6:0] opcode_q;
  logic       wait_en, wait_clr, wait_expired;

  assign wait_en  = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;
  assign wait_clr = (state_next != state_q);
  assign state    = state_q;

  wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (wait_clr),
    .en      (wait_en),
    .expired (wait_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q <= '0;
      illegal  <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      if (state_q == S_FETCH && mem_ready) begin
        opcode_q <= instr_opcode;
      end
      if (state_q == S_DECODE && !is_legal(opcode_q)) begin
        illegal <= 1'b1;
      end
      if (wait_expired) begin
        bus_err <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state_q;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ir_we      = 1'b0;
    reg_we     = 1'b0;
    pc_we      = 1'b0;
    retire     = 1'b0;
    pc_sel     = PC_PLUS4;
    wb_sel     = WB_ALU;
    alu_a_sel  = ALU_A_RS1;
    alu_b_sel  = ALU_B_RS2;

    unique case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (mem_ready) begin
          ir_we      = 1'b1;
          state_next = S_DECODE;
        end else if (wait_expired) begin
          state_next = S_TRAP;
        end
      end
      S_DECODE: begin
        state_next = is_legal(opcode_q) ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        alu_a_sel = (opcode_q == OP_AUIPC) ? ALU_A_PC : ALU_A_RS1;
        alu_b_sel = uses_imm(opcode_q) ? ALU_B_IMM : ALU_B_RS2;
        if (opcode_q == OP_LOAD || opcode_q == OP_STORE) begin
          state_next = S_MEM;
        end else if (opcode_q == OP_BRANCH) begin
          pc_we      = 1'b1;
          retire     = 1'b1;
          pc_sel     = branch_taken ? PC_IMM : PC_PLUS4;
          state_next = S_FETCH;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opcode_q == OP_STORE);
        if (mem_ready) begin
          if (opcode_q == OP_LOAD) begin
            state_next = S_WB;
          end else begin
            pc_we      = 1'b1;
            retire     = 1'b1;
            state_next = S_FETCH;
          end
        end else if (wait_expired) begin
          state_next = S_TRAP;
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        pc_we      = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
        unique case (opcode_q)
          OP_LOAD:          wb_sel = WB_LOAD;
          OP_JAL, OP_JALR:  wb_sel = WB_LINK;
          OP_LUI:           wb_sel = WB_IMM;
          default:          wb_sel = WB_ALU;
        endcase
        if (opcode_q == OP_JAL) begin
          pc_sel = PC_IMM;
        end else if (opcode_q == OP_JALR) begin
          pc_sel = PC_ALU;
        end
      end
      S_TRAP: begin
        state_next = S_TRAP;
      end
      default: begin
        state_next = S_TRAP;
      end
    endcase

    // Reset is asynchronous, so the outputs must go quiet without waiting for an edge
    if (!rst_n) begin
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      ir_we     = 1'b0;
      reg_we    = 1'b0;
      pc_we     = 1'b0;
      retire    = 1'b0;
      pc_sel    = PC_PLUS4;
      wb_sel    = WB_ALU;
      alu_a_sel = ALU_A_RS1;
      alu_b_sel = ALU_B_RS2;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] instr_opcode = 7'd0;
  logic       mem_ready = 1'b0;
  logic       branch_taken = 1'b0;
  logic       imem_req, dmem_req, dmem_we, ir_we, reg_we, pc_we, retire;
  logic [1:0] pc_sel, wb_sel;
  logic       alu_a_sel, alu_b_sel, illegal, bus_err;
  logic [2:0] state;
  logic [15:0] obs;

  int checks = 0;
  int errors = 0;

  multicycle_ctrl #(.TIMEOUT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_opcode (instr_opcode),
    .mem_ready    (mem_ready),
    .branch_taken (branch_taken),
    .imem_req     (imem_req),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .ir_we        (ir_we),
    .reg_we       (reg_we),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .alu_a_sel    (alu_a_sel),
    .alu_b_sel    (alu_b_sel),
    .wb_sel       (wb_sel),
    .retire       (retire),
    .illegal      (illegal),
    .bus_err      (bus_err),
    .state        (state)
  );

  always #5 clk = ~clk;

  // strobe field order: imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, retire
  assign obs = {state, imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, retire,
                pc_sel, wb_sel, alu_a_sel, alu_b_sel};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic ex(input string tag, input logic [2:0] st, input logic [6:0] str,
                    input logic [1:0] pcs, input logic [1:0] wbs, input logic [1:0] alu);
    chk(tag, {16'd0, obs}, {16'd0, st, str, pcs, wbs, alu});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_wb(input string tag, input logic [6:0] op, input logic [1:0] alu,
                        input logic [1:0] wbs, input logic [1:0] pcs);
    tick(); instr_opcode = op; mem_ready = 1'b1; #1;
    ex({tag, "_fetch"}, 3'd0, 7'b1100000, 2'd0, 2'd0, 2'b00);
    tick(); mem_ready = 1'b0; #1;
    ex({tag, "_decode"}, 3'd1, 7'b0000000, 2'd0, 2'd0, 2'b00);
    tick(); #1;
    ex({tag, "_exec"}, 3'd2, 7'b0000000, 2'd0, 2'd0, alu);
    tick(); #1;
    ex({tag, "_wb"}, 3'd4, 7'b0000111, pcs, wbs, 2'b00);
  endtask

  initial begin
    mem_ready = 1'b1;
    #1;
    ex("reset_outputs", 3'd0, 7'b0000000, 2'd0, 2'd0, 2'b00);
    chk("reset_flags", {30'd0, illegal, bus_err}, 32'd0);
    tick(); rst_n = 1'b1; mem_ready = 1'b0; #1;
    ex("release_fetch", 3'd0, 7'b1000000, 2'd0, 2'd0, 2'b00);

    run_wb("rr",    7'b0110011, 2'b00, 2'd0, 2'd0);
    run_wb("jal",   7'b1101111, 2'b00, 2'd2, 2'd1);
    run_wb("jalr",  7'b1100111, 2'b01, 2'd2, 2'd2);
    run_wb("lui",   7'b0110111, 2'b00, 2'd3, 2'd0);
    run_wb("auipc", 7'b0010111, 2'b11, 2'd0, 2'd0);

    // load: dmem ready after two wait cycles, retires in cycle 7
    tick(); instr_opcode = 7'b0000011; mem_ready = 1'b1; #1;
    ex("ld_fetch", 3'd0, 7'b1100000, 2'd0, 2'd0, 2'b00);
    tick(); mem_ready = 1'b0; #1;
    ex("ld_decode", 3'd1, 7'b0000000, 2'd0, 2'd0, 2'b00);
    tick(); #1;
    ex("ld_exec", 3'd2, 7'b0000000, 2'd0, 2'd0, 2'b01);
    tick(); #1;
    ex("ld_mem_w1", 3'd3, 7'b0010000, 2'd0, 2'd0, 2'b00);
    tick(); #1;
    ex("ld_mem_w2", 3'd3, 7'b0010000, 2'd0, 2'd0, 2'b00);
    tick(); mem_ready = 1'b1; #1;
    ex("ld_mem_rdy", 3'd3, 7'b0010000, 2'd0, 2'd0, 2'b00);
    tick(); mem_ready = 1'b0; #1;
    ex("ld_wb", 3'd4, 7'b0000111, 2'd0, 2'd1, 2'b00);

    // store completing normally
    tick(); instr_opcode = 7'b0100011; mem_ready = 1'b1; #1;
    ex("st_fetch", 3'd0, 7'b1100000, 2'd0, 2'd0, 2'b00);
    tick(); mem_ready = 1'b0; #1;
    ex("st_decode", 3'd1, 7'b0000000, 2'd0, 2'd0, 2'b00);
    tick(); #1;
    ex("st_exec", 3'd2, 7'b0000000, 2'd0, 2'd0, 2'b01);
    tick(); mem_ready = 1'b1; #1;
    ex("st_mem_rdy", 3'd3, 7'b0011011, 2'd0, 2'd0, 2'b00);
    tick(); mem_ready = 1'b0; #1;
    ex("st_next_fetch", 3'd0, 7'b1000000, 2'd0, 2'd0, 2'b00);

    // branch taken then not taken
    tick(); instr_opcode = 7'b1100011; mem_ready = 1'b1; branch_taken = 1'b1; #1;
    ex("bt_fetch", 3'd0, 7'b1100000, 2'd0, 2'd0, 2'b00);
    tick(); mem_ready = 1'b0; #1;
    ex("bt_decode", 3'd1, 7'b0000000, 2'd0, 2'd0, 2'b00);
    tick(); #1;
    ex("bt_exec", 3'd2, 7'b0000011, 2'd1, 2'd0, 2'b00);
    tick(); mem_ready = 1'b1; branch_taken = 1'b0; #1;
    ex("bn_fetch", 3'd0, 7'b1100000, 2'd0, 2'd0, 2'b00);
    tick(); mem_ready = 1'b0; #1;
    ex("bn_decode", 3'd1, 7'b0000000, 2'd0, 2'd0, 2'b00);
    tick(); #1;
    ex("bn_exec", 3'd2, 7'b0000011, 2'd0, 2'd0, 2'b00);

    // reset pulsed while a store waits in MEM
    tick(); instr_opcode = 7'b0100011; mem_ready = 1'b1; #1;
    ex("rs_fetch", 3'd0, 7'b1100000, 2'd0, 2'd0, 2'b00);
    tick(); mem_ready = 1'b0; #1;
    tick(); #1;
    tick(); #1;
    ex("rs_mem", 3'd3, 7'b0011000, 2'd0, 2'd0, 2'b00);
    rst_n = 1'b0; #1;
    ex("rs_in_reset", 3'd0, 7'b0000000, 2'd0, 2'd0, 2'b00);
    rst_n = 1'b1; #1;
    ex("rs_released", 3'd0, 7'b1000000, 2'd0, 2'd0, 2'b00);

    run_wb("imm", 7'b0010011, 2'b01, 2'd0, 2'd0);

    // ready in the 4th wait cycle beats the timeout
    tick(); mem_ready = 1'b0; #1;
    ex("to_w1", 3'd0, 7'b1000000, 2'd0, 2'd0, 2'b00);
    tick(); #1;
    tick(); #1;
    ex("to_w3", 3'd0, 7'b1000000, 2'd0, 2'd0, 2'b00);
    tick(); mem_ready = 1'b1; #1;
    ex("to_rdy_c4", 3'd0, 7'b1100000, 2'd0, 2'd0, 2'b00);
    tick(); mem_ready = 1'b0; #1;
    ex("to_decode", 3'd1, 7'b0000000, 2'd0, 2'd0, 2'b00);
    chk("to_no_bus_err", {31'd0, bus_err}, 32'd0);
    tick(); #1;
    tick(); #1;
    ex("to_wb", 3'd4, 7'b0000111, 2'd0, 2'd0, 2'b00);

    // four idle cycles in FETCH trap with bus_err
    tick(); #1;
    tick(); #1;
    tick(); #1;
    tick(); #1;
    ex("to_w4", 3'd0, 7'b1000000, 2'd0, 2'd0, 2'b00);
    tick(); #1;
    ex("to_trap", 3'd5, 7'b0000000, 2'd0, 2'd0, 2'b00);
    chk("to_flags", {30'd0, illegal, bus_err}, 32'd1);
    tick(); mem_ready = 1'b1; #1;
    ex("to_trap_hold", 3'd5, 7'b0000000, 2'd0, 2'd0, 2'b00);

    rst_n = 1'b0; mem_ready = 1'b0; #1;
    chk("trap_reset_flags", {27'd0, state, illegal, bus_err}, 32'd0);
    rst_n = 1'b1;

    // illegal opcode traps and stays quiet until reset
    tick(); instr_opcode = 7'b1111111; mem_ready = 1'b1; #1;
    ex("il_fetch", 3'd0, 7'b1100000, 2'd0, 2'd0, 2'b00);
    tick(); mem_ready = 1'b0; #1;
    ex("il_decode", 3'd1, 7'b0000000, 2'd0, 2'd0, 2'b00);
    for (int i = 0; i < 11; i++) begin
      tick(); mem_ready = i[0]; branch_taken = i[1]; #1;
      ex("il_trap", 3'd5, 7'b0000000, 2'd0, 2'd0, 2'b00);
      chk("il_flags", {30'd0, illegal, bus_err}, 32'd2);
    end
    rst_n = 1'b0; #1;
    chk("il_reset", {27'd0, state, illegal, bus_err}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
